// File: rtl/pot_scan_sched.sv
// pot_scan_sched: round-robin ADC128S scheduler for the six equalizer pots.
// Define POT_SMOOTH_EN to low-pass each stored sample with a 1/4 IIR step.
module pot_scan_sched #(
    parameter logic [15:0] ROUND_CYC = 16'd4096,
    parameter logic [11:0] TMO_CYC   = 12'd1024,
    parameter logic [11:0] GAIN_RST  = 12'h800
) (
    input  logic        clk,
    input  logic        rst,
    output logic        strt_cnv,
    output logic [2:0]  chnnl,
    input  logic        cnv_cmplt,
    input  logic [11:0] res,
    output logic [11:0] POT_LP,
    output logic [11:0] POT_B1,
    output logic [11:0] POT_B2,
    output logic [11:0] POT_B3,
    output logic [11:0] POT_HP,
    output logic [11:0] VOLUME,
    output logic        round_done,
    output logic        tmo_err
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_STORE,
        S_NEXT
    } state_t;

    state_t      state_q;
    logic [15:0] rnd_q;
    logic [15:0] rnd_d;
    logic        rnd_tc;
    logic [11:0] tmo_q;
    logic [11:0] tmo_d;
    logic        tmo_hit;
    logic [2:0]  slot_q;
    logic [2:0]  slot_d;
    logic [2:0]  chnnl_q;
    logic [11:0] res_q;
    logic [11:0] pot_q [6];
    logic [11:0] cur;
    logic [11:0] upd_d;
    logic        strt_q;
    logic        done_q;
    logic        err_q;

`ifdef POT_SMOOTH_EN
    logic [5:0]         seeded_q;
    logic signed [12:0] diff;
    logic signed [12:0] step;
`endif

    // Slot order LP, B1, B2, B3, HP, VOL mapped onto the board's ADC channels
    function automatic logic [2:0] ch_of(input logic [2:0] s);
        case (s)
            3'd0:    return 3'd1;
            3'd1:    return 3'd0;
            3'd2:    return 3'd4;
            3'd3:    return 3'd2;
            3'd4:    return 3'd3;
            3'd5:    return 3'd7;
            default: return 3'd1;
        endcase
    endfunction

    always_comb begin
        rnd_tc  = (rnd_q == ROUND_CYC - 16'd1);
        rnd_d   = rnd_tc ? 16'd0 : rnd_q + 16'd1;
        tmo_hit = (tmo_q == TMO_CYC - 12'd1);
        tmo_d   = tmo_q + 12'd1;
        slot_d  = slot_q + 3'd1;
        cur     = pot_q[slot_q];
`ifdef POT_SMOOTH_EN
        diff  = $signed({1'b0, res_q}) - $signed({1'b0, cur});
        step  = diff >>> 2;
        upd_d = seeded_q[slot_q] ? cur + step[11:0] : res_q;
`else
        upd_d = res_q;
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            rnd_q    <= 16'd0;
            tmo_q    <= 12'd0;
            slot_q   <= 3'd0;
            chnnl_q  <= 3'd1;
            res_q    <= 12'd0;
            strt_q   <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            pot_q[0] <= GAIN_RST;
            pot_q[1] <= GAIN_RST;
            pot_q[2] <= GAIN_RST;
            pot_q[3] <= GAIN_RST;
            pot_q[4] <= GAIN_RST;
            pot_q[5] <= 12'h000;
`ifdef POT_SMOOTH_EN
            seeded_q <= 6'd0;
`endif
        end else begin
            // Timer free-runs; a start missed while busy is simply dropped
            rnd_q  <= rnd_d;
            strt_q <= 1'b0;
            done_q <= 1'b0;
            unique case (state_q)
                S_IDLE: begin
                    if (rnd_tc) begin
                        slot_q  <= 3'd0;
                        chnnl_q <= ch_of(3'd0);
                        tmo_q   <= 12'd0;
                        strt_q  <= 1'b1;
                        state_q <= S_REQ;
                    end
                end
                S_REQ: begin
                    tmo_q   <= tmo_d;
                    state_q <= S_WAIT;
                end
                S_WAIT: begin
                    if (cnv_cmplt) begin
                        res_q   <= res;
                        state_q <= S_STORE;
                    end else if (tmo_hit) begin
                        err_q   <= 1'b1;
                        state_q <= S_NEXT;
                    end else begin
                        tmo_q <= tmo_d;
                    end
                end
                S_STORE: begin
                    pot_q[slot_q] <= upd_d;
`ifdef POT_SMOOTH_EN
                    seeded_q[slot_q] <= 1'b1;
`endif
                    state_q <= S_NEXT;
                end
                S_NEXT: begin
                    if (slot_q == 3'd5) begin
                        done_q  <= 1'b1;
                        state_q <= S_IDLE;
                    end else begin
                        slot_q  <= slot_d;
                        chnnl_q <= ch_of(slot_d);
                        tmo_q   <= 12'd0;
                        strt_q  <= 1'b1;
                        state_q <= S_REQ;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign strt_cnv   = strt_q;
    assign chnnl      = chnnl_q;
    assign round_done = done_q;
    assign tmo_err    = err_q;
    assign POT_LP     = pot_q[0];
    assign POT_B1     = pot_q[1];
    assign POT_B2     = pot_q[2];
    assign POT_B3     = pot_q[3];
    assign POT_HP     = pot_q[4];
    assign VOLUME     = pot_q[5];

endmodule

// File: doc/pot_scan_sched.md
# pot_scan_sched

Round-robin scheduler that owns the A2D interface to the ADC128S slide-pot converter. It sequences one conversion per equalizer control: LP, B1, B2, B3, HP and VOLUME. Each result lands in a dedicated 12-bit register that feeds the band-gain and volume inputs of the equalizer datapath. A round runs every `ROUND_CYC` clocks, with per-conversion timeout detection.

## Interface
Parameters:
- `ROUND_CYC`, 16'd4096: clocks from the start of one round to the start of the next (min 64).
- `TMO_CYC`, 12'd1024: max clocks to wait for `cnv_cmplt` after `strt_cnv`.
- `GAIN_RST`, 12'h800: reset value of the five band-gain registers (unity).

Ports:
- `clk` in 1: system clock; one clock only.
- `rst` in 1: synchronous reset, active-high.
- `strt_cnv` out 1: one-cycle pulse requesting an A2D conversion.
- `chnnl` out 3: ADC channel of the current conversion.
- `cnv_cmplt` in 1: one-cycle pulse; `res` is valid this cycle.
- `res` in 12: conversion result, unsigned.
- `POT_LP`, `POT_B1`, `POT_B2`, `POT_B3`, `POT_HP` out 12 each: band-gain registers.
- `VOLUME` out 12: volume register.
- `round_done` out 1: one-cycle pulse after the sixth store of a round.
- `tmo_err` out 1: sticky; set on any timeout, cleared only by `rst`.

## Operation
- Slot order and channel map: slot 0 LP = ch1, slot 1 B1 = ch0, slot 2 B2 = ch4, slot 3 B3 = ch2, slot 4 HP = ch3, slot 5 VOL = ch7.
- FSM states:
  - IDLE: round timer running; at terminal count, slot = 0, go to REQ.
  - REQ: assert `strt_cnv` for 1 cycle, clear the timeout counter, go to WAIT.
  - WAIT: on `cnv_cmplt`, go to STORE. If the timeout counter reaches `TMO_CYC-1` with no `cnv_cmplt`, set `tmo_err`, keep the old register value, go to NEXT.
  - STORE: update the slot register from the captured `res`, go to NEXT.
  - NEXT: if slot = 5, pulse `round_done` and go to IDLE; else slot + 1, go to REQ.
- `res` is captured into an internal latch in the `cnv_cmplt` cycle; STORE uses the latch.
- `chnnl` changes only on entry to REQ and holds through NEXT; in IDLE it holds the last value.
- `cnv_cmplt` outside WAIT is ignored and stores nothing.
- If `cnv_cmplt` arrives in the same cycle the timeout expires, `cnv_cmplt` wins: no error, proceed to STORE.
- The round timer free-runs from reset and is independent of conversion latency. If a round overruns `ROUND_CYC`, the next start is taken at the first terminal count seen in IDLE; missed counts are not queued.

## Timing
- Reset values:
  - `strt_cnv` = 0, `chnnl` = 3'd1, `round_done` = 0, `tmo_err` = 0.
  - All five `POT_*` = `GAIN_RST`; `VOLUME` = 12'h000 (silent at power-up).
  - FSM in IDLE; round timer and slot = 0.
- First `strt_cnv` occurs `ROUND_CYC` clocks after `rst` deasserts.
- Register update latency: the register changes on the 2nd clock edge after the `cnv_cmplt` cycle (edge 1 enters STORE, edge 2 writes).
- From `cnv_cmplt` to the next `strt_cnv` is 3 cycles: STORE, NEXT, REQ.
- `rst` asserted mid-round (any state) returns to reset values on the next edge. A pending `cnv_cmplt` after reset is ignored because the FSM is in IDLE.

## Configuration
- `POT_SMOOTH_EN` defined: STORE performs a first-order IIR update, `reg <= reg + ((res - reg) >>> 2)`.
  - The difference is 13-bit signed; shift is arithmetic; the sum is truncated to 12 bits and cannot overflow.
  - A per-slot `seeded` flag (cleared by `rst`) makes the first store after reset load `res` directly.
- `POT_SMOOTH_EN` undefined: STORE loads `res` directly; no `seeded` flags.

## Test plan
- Reset then idle, `ROUND_CYC` = 64:
  - Check: `POT_*` = 0x800, `VOLUME` = 0, no `strt_cnv` before cycle 64.
  - Check: `chnnl` sequence 1, 0, 4, 2, 3, 7, then one `round_done`.
- Stub A2D returns `res` = 0xA5A + chnnl with a 10-cycle latency:
  - Check: after one round, `POT_LP` = 0xA5B, `POT_B1` = 0xA5A, `POT_B2` = 0xA5E, `POT_B3` = 0xA5C, `POT_HP` = 0xA5D, `VOLUME` = 0xA61.
  - Check: update occurs 2 edges after `cnv_cmplt`.
- Stub suppresses `cnv_cmplt` for slot 2, `TMO_CYC` = 16:
  - Check: `tmo_err` rises 16 cycles after that `strt_cnv`, `POT_B2` stays 0x800, slot 3 proceeds.
  - Check: `tmo_err` stays high through the next round.
- `cnv_cmplt` exactly in the timeout cycle → `tmo_err` stays 0 and the value is stored. Stray `cnv_cmplt` in IDLE → no register changes.
- Assert `rst` while in WAIT for slot 4:
  - Check: all outputs return to reset values next edge; the late `cnv_cmplt` is ignored.
  - Check: the next round starts `ROUND_CYC` cycles after release.
- With `POT_SMOOTH_EN`:
  - First `VOLUME` sample 0x400 → `VOLUME` = 0x400.
  - Next sample 0x800 → 0x500, then 0x5C0.
  - Sample 0x000 from 0x5C0 → 0x450.
